// File: rtl/joy_md_reader_if.sv
// Pin and decoded-word bundle between the Mega Drive pad reader and its pads/consumer.
// slave is the reader's view; master is the pads-plus-consumer side.
interface joy_md_reader_if;
  logic [5:0]  joy1_in;
  logic [5:0]  joy2_in;
  logic        joy_select;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        joy_valid;

  modport master (output joy1_in, joy2_in, input joy_select, joy1, joy2, joy_valid);
  modport slave  (input joy1_in, joy2_in, output joy_select, joy1, joy2, joy_valid);
endinterface

// File: rtl/joy_md_reader.sv
// Two-port Mega Drive pad reader: 8-phase SELECT scan per period, 3/6-button decode.
// state    | meaning
// ST_SCAN  | walking phases S0..S7, phase timer running
// ST_IDLE  | SELECT parked high until the scan counter wraps
module joy_md_reader #(
  parameter int PHASE_CYC = 70,
  parameter int SCAN_CYC  = 116667
) (
  input logic             clk,
  input logic             rst_n,
  joy_md_reader_if.slave  bus
);

  localparam logic [0:0]  ST_SCAN   = 1'b0;
  localparam logic [0:0]  ST_IDLE   = 1'b1;
  localparam logic [16:0] SCAN_LAST = 17'(SCAN_CYC - 1);
  localparam logic [9:0]  PH_LAST   = 10'(PHASE_CYC - 1);

  logic [0:0]  state;
  logic [16:0] cnt;
  logic [9:0]  ph_tmr;
  logic [2:0]  ph;
  logic        sel_r;
  logic        valid_r;
  logic [15:0] joy1_r, joy2_r;

  logic [5:0]  j1_m, j1_s, j2_m, j2_s;
  logic [5:0]  j1_s0, j2_s0;
  logic [3:0]  j1_s1, j2_s1, j1_s5, j2_s5, j1_s6, j2_s6;

  logic tc;
  logic last;

  assign tc   = (state == ST_SCAN) && (ph_tmr == 10'd0);
  assign last = tc && (ph == 3'd7);

  // s1 holds pins [5:2] of S1; s5 and s6 hold pins [3:0] of their phases.
  function automatic logic [15:0] decode(input logic [5:0] s0, input logic [3:0] s1,
                                         input logic [3:0] s5, input logic [3:0] s6);
    logic        present;
    logic        six;
    logic [15:0] w;
    present = ~s1[0] & ~s1[1];
    six     = ~|s5;
    w = {2'b00, six, 1'b1, ~s6[3], ~s6[0], ~s6[1], ~s6[2], ~s1[3], ~s1[2],
         ~s0[5], ~s0[4], ~s0[0], ~s0[1], ~s0[2], ~s0[3]};
    if (!six)     w[11:8] = 4'h0;
    if (!present) w = 16'h0000;
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_SCAN;
      cnt     <= '0;
      ph_tmr  <= PH_LAST;
      ph      <= '0;
      sel_r   <= 1'b1;
      valid_r <= 1'b0;
      joy1_r  <= '0;
      joy2_r  <= '0;
      j1_m    <= '0;
      j1_s    <= '0;
      j2_m    <= '0;
      j2_s    <= '0;
      j1_s0   <= '0;
      j2_s0   <= '0;
      j1_s1   <= '0;
      j2_s1   <= '0;
      j1_s5   <= '0;
      j2_s5   <= '0;
      j1_s6   <= '0;
      j2_s6   <= '0;
    end else begin
      j1_m <= bus.joy1_in;
      j1_s <= j1_m;
      j2_m <= bus.joy2_in;
      j2_s <= j2_m;

      cnt   <= (cnt == SCAN_LAST) ? 17'd0 : cnt + 17'd1;
      // Registered from the current phase so every edge lags its boundary count by one.
      sel_r <= !((state == ST_SCAN) && ph[0]);

      case (state)
        ST_SCAN: begin
          if (ph_tmr == 10'd0) begin
            ph_tmr <= PH_LAST;
            ph     <= ph + 3'd1;
            if (ph == 3'd7) state <= ST_IDLE;
          end else begin
            ph_tmr <= ph_tmr - 10'd1;
          end
        end
        default: begin
          if (cnt == SCAN_LAST) begin
            state  <= ST_SCAN;
            ph     <= '0;
            ph_tmr <= PH_LAST;
          end
        end
      endcase

      if (tc) begin
        case (ph)
          3'd0: begin j1_s0 <= j1_s;      j2_s0 <= j2_s;      end
          3'd1: begin j1_s1 <= j1_s[5:2]; j2_s1 <= j2_s[5:2]; end
          3'd5: begin j1_s5 <= j1_s[3:0]; j2_s5 <= j2_s[3:0]; end
          3'd6: begin j1_s6 <= j1_s[3:0]; j2_s6 <= j2_s[3:0]; end
          default: ;
        endcase
      end

      valid_r <= last;
      if (last) begin
        joy1_r <= decode(j1_s0, j1_s1, j1_s5, j1_s6);
        joy2_r <= decode(j2_s0, j2_s1, j2_s5, j2_s6);
      end
    end
  end

  assign bus.joy_select = sel_r;
  assign bus.joy_valid  = valid_r;
  assign bus.joy1       = joy1_r;
  assign bus.joy2       = joy2_r;

endmodule

// File: tb/tb_joy_md_reader.sv
// Bench for joy_md_reader: behavioural pads on a shared SELECT, expected words from button sets.
// The scan period is shortened so many scans fit; the pad idle timeout is scaled with it.
module tb_joy_md_reader;
  localparam int PHASE   = 70;
  localparam int SCAN    = 1600;
  localparam int TIMEOUT = 800;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  joy_md_reader_if bus ();

  joy_md_reader #(.PHASE_CYC(PHASE), .SCAN_CYC(SCAN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Pad configuration: kind 0 = unplugged, 1 = 3-button, 2 = 6-button.
  // Buttons are held in output word order [11:0].
  int          kind1 = 0, kind2 = 0;
  logic [11:0] btn1 = '0, btn2 = '0;

  logic [2:0] pad_ph = '0;
  int         pad_idle = 0;
  logic       sel_q = 1'b1;
  int         mcnt = 0;

  always @(posedge clk) begin
    if (bus.joy_select !== sel_q) begin
      pad_ph   <= pad_ph + 3'd1;
      pad_idle <= 0;
    end else if (pad_idle >= TIMEOUT) begin
      pad_ph <= '0;
    end else begin
      pad_idle <= pad_idle + 1;
    end
    sel_q <= bus.joy_select;
  end

  always @(posedge clk) begin
    if (!rst_n) mcnt <= 0;
    else        mcnt <= (mcnt == SCAN - 1) ? 0 : mcnt + 1;
  end

  function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                          input logic [2:0] ph, input logic sel);
    logic [5:0] act;
    if (kind == 0) return 6'h3F;
    if (sel) begin
      if (kind == 2 && ph == 3'd6) act = {b[5], b[4], b[11], b[8], b[9], b[10]};
      else                         act = {b[5], b[4], b[0], b[1], b[2], b[3]};
    end else begin
      if (kind == 2 && ph == 3'd5) act = {b[7], b[6], 4'hF};
      else                         act = {b[7], b[6], 2'b11, b[2], b[3]};
    end
    return ~act;
  endfunction

  function automatic logic [15:0] exp_word(input int kind, input logic [11:0] b);
    if (kind == 1) return 16'h1000 | {8'h00, b[7:0]};
    if (kind == 2) return 16'h3000 | {4'h0, b};
    return 16'h0000;
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[3] && b[2]) b[2] = 1'b0;
    if (b[1] && b[0]) b[0] = 1'b0;
    return b;
  endfunction

  assign bus.joy1_in = pad_pins(kind1, btn1, pad_ph, bus.joy_select);
  assign bus.joy2_in = pad_pins(kind2, btn2, pad_ph, bus.joy_select);

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.joy_valid && n <= SCAN + 20);
    if (!bus.joy_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL valid_timeout: no joy_valid within %0d cycles", n);
    end
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mcnt != target && n <= SCAN + 20);
  endtask

  task automatic test_reset();
    int sel_err = 0, val_err = 0, first_sel = -1, first_val = -1;
    logic exp_sel;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.joy_select !== 1'b1 || bus.joy1 !== 16'h0 || bus.joy2 !== 16'h0 || bus.joy_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: sel=%b joy1=%h joy2=%h valid=%b, need 1/0000/0000/0",
               bus.joy_select, bus.joy1, bus.joy2, bus.joy_valid);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      exp_sel = (i >= 71 && i <= 8 * PHASE) ? (((i - 1) / PHASE) % 2 == 0) : 1'b1;
      if (bus.joy_select !== exp_sel) begin
        sel_err++;
        if (first_sel < 0) first_sel = i;
      end
      if (bus.joy_valid !== (i == 8 * PHASE)) begin
        val_err++;
        if (first_val < 0) first_val = i;
      end
    end
    tests_run++;
    if (sel_err != 0) begin
      tests_failed++;
      $display("FAIL select_sequence: %0d wrong cycles, first at cycle %0d", sel_err, first_sel);
    end
    tests_run++;
    if (val_err != 0) begin
      tests_failed++;
      $display("FAIL first_valid_timing: %0d wrong cycles, first at cycle %0d, need pulse only at 560", val_err, first_val);
    end
  endtask

  task automatic test_no_pads();
    int n;
    kind1 = 0;
    kind2 = 0;
    wait_valid(n);
    tests_run++;
    if (mcnt != 8 * PHASE || bus.joy1 !== 16'h0 || bus.joy2 !== 16'h0) begin
      tests_failed++;
      $display("FAIL no_pads: cnt=%0d joy1=%h joy2=%h, need 560/0000/0000", mcnt, bus.joy1, bus.joy2);
    end
    wait_valid(n);
    tests_run++;
    if (n != SCAN) begin
      tests_failed++;
      $display("FAIL wrap_period: valid spacing %0d, need %0d", n, SCAN);
    end
  endtask

  task automatic test_three_button();
    int n;
    kind1 = 1; btn1 = 12'h041;
    kind2 = 0;
    wait_valid(n);
    tests_run++;
    if (bus.joy1 !== 16'h1041 || bus.joy2 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL three_button: joy1=%h joy2=%h, need 1041/0000", bus.joy1, bus.joy2);
    end
    @(negedge clk);
    tests_run++;
    if (bus.joy_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_width: joy_valid=%b one cycle after strobe, need 0", bus.joy_valid);
    end
  endtask

  task automatic test_six_button();
    int n;
    kind1 = 0;
    kind2 = 2; btn2 = 12'h908;
    wait_valid(n);
    tests_run++;
    if (bus.joy2 !== 16'h3908 || bus.joy1 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL six_button: joy2=%h joy1=%h, need 3908/0000", bus.joy2, bus.joy1);
    end
    btn2 = 12'h000;
    wait_valid(n);
    tests_run++;
    if (bus.joy2 !== 16'h3000) begin
      tests_failed++;
      $display("FAIL six_idle: joy2=%h, need 3000", bus.joy2);
    end
  endtask

  task automatic test_random();
    int n;
    logic [15:0] e1, e2;
    for (int it = 0; it < 8; it++) begin
      kind1 = int'($urandom_range(0, 2));
      kind2 = int'($urandom_range(0, 2));
      btn1  = rand_btn();
      btn2  = rand_btn();
      e1 = exp_word(kind1, btn1);
      e2 = exp_word(kind2, btn2);
      wait_valid(n);
      tests_run++;
      if (bus.joy1 !== e1) begin
        tests_failed++;
        $display("FAIL random_joy1[%0d]: got %h, need %h (kind %0d btn %h)", it, bus.joy1, e1, kind1, btn1);
      end
      tests_run++;
      if (bus.joy2 !== e2) begin
        tests_failed++;
        $display("FAIL random_joy2[%0d]: got %h, need %h (kind %0d btn %h)", it, bus.joy2, e2, kind2, btn2);
      end
    end
  endtask

  task automatic test_unplug();
    int n;
    logic [15:0] e1;
    kind1 = 2; btn1 = rand_btn();
    kind2 = 0;
    e1 = exp_word(kind1, btn1);
    wait_valid(n);
    tests_run++;
    if (bus.joy1 !== e1) begin
      tests_failed++;
      $display("FAIL unplug_before: joy1=%h, need %h", bus.joy1, e1);
    end
    kind1 = 0;
    wait_cnt(1200);
    tests_run++;
    if (bus.joy1 !== e1) begin
      tests_failed++;
      $display("FAIL unplug_hold: joy1=%h before next strobe, need %h", bus.joy1, e1);
    end
    wait_valid(n);
    tests_run++;
    if (bus.joy1 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL unplug_after: joy1=%h, need 0000", bus.joy1);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    kind1 = 1; btn1 = 12'h010;
    kind2 = 0;
    wait_valid(n);
    tests_run++;
    if (bus.joy1 !== 16'h1010) begin
      tests_failed++;
      $display("FAIL midreset_setup: joy1=%h, need 1010", bus.joy1);
    end
    wait_cnt(300);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.joy_select !== 1'b1 || bus.joy1 !== 16'h0 || bus.joy2 !== 16'h0 || bus.joy_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: sel=%b joy1=%h joy2=%h valid=%b, need 1/0000/0000/0",
               bus.joy_select, bus.joy1, bus.joy2, bus.joy_valid);
    end
    rst_n = 1'b1;
    wait_valid(n);
    tests_run++;
    if (n != 8 * PHASE) begin
      tests_failed++;
      $display("FAIL midreset_latency: strobe %0d cycles after release, need %0d", n, 8 * PHASE);
    end
    tests_run++;
    if (bus.joy1 !== 16'h1010) begin
      tests_failed++;
      $display("FAIL midreset_word: joy1=%h, need 1010", bus.joy1);
    end
  endtask

  initial begin
    test_reset();
    test_no_pads();
    test_three_button();
    test_six_button();
    test_random();
    test_unplug();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
